// File: rtl/fetch_predict.sv
// Fetch PC generator with a 2-bit bimodal BHT, redirect/flush priority and branch/mispredict counters.
// Latency: next_pc, id_pred and counters register on each non-stalled edge; flushes are combinational. Backpressure: stall freezes all state.
module fetch_predict #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              BHT_ENTRIES = 64,
  parameter int              CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             id_branch,
  input  logic             id_jal,
  input  logic [XLEN-1:0]  id_pc_imm,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jalr,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_pc_imm,
  input  logic [XLEN-1:0]  ex_rs1_imm,
  output logic [XLEN-1:0]  pc,
  output logic [1:0]       id_pred,
  output logic             id_flush,
  output logic             ex_flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int IW = $clog2(BHT_ENTRIES);

  logic [1:0]      bht [BHT_ENTRIES];
  logic [IW-1:0]   rd_idx;
  logic [IW-1:0]   wr_idx;
  logic            ex_mispred;
  logic            ex_jalr_act;
  logic            ex_resolve;
  logic            id_take;
  logic [XLEN-1:0] next_pc;

  assign rd_idx      = pc[IW+1:2];
  assign wr_idx      = ex_pc[IW+1:2];
  assign ex_mispred  = ex_valid & ex_branch & (ex_taken != ex_pred_taken);
  assign ex_jalr_act = ex_valid & ex_jalr;
  assign ex_resolve  = ex_valid & ex_branch;
  assign id_take     = (id_branch & id_pred[1]) | id_jal;

  // EX redirects outrank any ID redirect; flushes stay low during reset.
  always_comb begin
    next_pc  = pc + XLEN'(4);
    id_flush = 1'b0;
    ex_flush = 1'b0;
    if (!rst) begin
      if (ex_mispred) begin
        next_pc  = ex_taken ? ex_pc_imm : ex_pc + XLEN'(4);
        id_flush = 1'b1;
        ex_flush = 1'b1;
      end else if (ex_jalr_act) begin
        next_pc  = {ex_rs1_imm[XLEN-1:1], 1'b0};
        id_flush = 1'b1;
        ex_flush = 1'b1;
      end else if (id_take) begin
        next_pc  = id_pc_imm;
        id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      id_pred       <= 2'b00;
      br_count      <= '0;
      mispred_count <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (!stall) begin
      pc      <= next_pc;
      // Lookup sees the pre-update counter even when the update hits the same entry.
      id_pred <= id_flush ? 2'b00 : bht[rd_idx];
      if (ex_resolve) begin
        if (ex_taken) begin
          if (bht[wr_idx] != 2'b11) bht[wr_idx] <= bht[wr_idx] + 2'd1;
        end else begin
          if (bht[wr_idx] != 2'b00) bht[wr_idx] <= bht[wr_idx] - 2'd1;
        end
        if (br_count != '1) br_count <= br_count + CNT_W'(1);
      end
      if (ex_mispred && mispred_count != '1) mispred_count <= mispred_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/fetch_predict.md
FETCH_PREDICT -- requirements
Module: fetch_predict

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-003 SHALL have parameter BHT_ENTRIES, default 64, meaning number of 2-bit counters; power of 2, 2..1024.
REQ-004 SHALL have parameter CNT_W, default 32, meaning width of performance counters.
REQ-005 SHALL have port clk, input, 1, meaning single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port stall, input, 1, meaning hold PC, ID prediction and counters this cycle.
REQ-008 SHALL have port id_branch, input, 1, meaning ID instruction is a conditional branch.
REQ-009 SHALL have port id_jal, input, 1, meaning ID instruction is JAL.
REQ-010 SHALL have port id_pc_imm, input, XLEN, meaning ID PC + immediate.
REQ-011 SHALL have port ex_valid, input, 1, meaning EX holds a live instruction.
REQ-012 SHALL have ports ex_branch and ex_jalr, input, 1 each, meaning EX instruction class.
REQ-013 SHALL have ports ex_taken and ex_pred_taken, input, 1 each, meaning resolved outcome and prediction carried down the pipe.
REQ-014 SHALL have ports ex_pc, ex_pc_imm and ex_rs1_imm, input, XLEN each, meaning EX PC, branch target and JALR sum.
REQ-015 SHALL have port pc, output, XLEN, meaning registered fetch PC.
REQ-016 SHALL have port id_pred, output, 2, meaning registered counter value for the instruction now in ID.
REQ-017 SHALL have ports id_flush and ex_flush, output, 1 each, meaning kill ID / EX stage contents.
REQ-018 SHALL have ports br_count and mispred_count, output, CNT_W each, meaning resolved branches and mispredicts.

Function
REQ-019 SHALL index the BHT as IDX = pc[log2(BHT_ENTRIES)+1:2]; pc[1:0] ignored.
REQ-020 SHALL compute next_pc combinationally with the priority below; the highest-priority matching row wins.
- Priority 1, EX mispredict (ex_valid & ex_branch & ex_taken != ex_pred_taken): ex_pc_imm if ex_taken, else ex_pc+4; id_flush=1, ex_flush=1.
- Priority 2, EX JALR (ex_valid & ex_jalr): ex_rs1_imm & ~1; id_flush=1, ex_flush=1.
- Priority 3, ID taken prediction (id_branch & id_pred[1]) or id_jal: id_pc_imm; id_flush=1, ex_flush=0.
- Default: pc+4; no flush.
REQ-021 SHALL, on any cycle with stall=0, load pc <= next_pc; with stall=1 hold pc; flush outputs still driven combinationally.
REQ-022 SHALL, with stall=0, load id_pred <= BHT[IDX(pc)] when id_flush=0, and id_pred <= 2'b00 when id_flush=1.
REQ-023 SHALL, with stall=0 and ex_valid & ex_branch, saturating-update BHT[IDX(ex_pc)]: +1 if ex_taken (max 2'b11), -1 otherwise (min 2'b00).
REQ-024 SHALL return the pre-update counter when lookup and update hit the same index in one cycle (no bypass).
REQ-025 SHALL increment br_count on each REQ-023 update and mispred_count on each priority-1 event with stall=0; both saturate at all-ones.
REQ-026 SHALL wrap next_pc modulo 2^XLEN (pc+4 at 32'hFFFF_FFFC gives 0).
REQ-027 SHALL ignore id_* redirects whenever an EX redirect is active in the same cycle.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, set pc=RESET_PC, id_pred=2'b00, every BHT counter=2'b01, and both counters=0, overriding stall and all redirects.
REQ-029 SHALL drive id_flush=ex_flush=0 while rst=1, and SHALL apply reset mid-operation within one cycle with no residual state.

Verification
REQ-030 SHALL pass reset-then-run: rst 1 cycle, then 3 idle cycles -> pc = 0, 4, 8, 12; id_pred=00.
REQ-031 SHALL pass the BHT training case: 3 taken resolutions at ex_pc=0x40 -> counter 01->10->11->11; next fetch of 0x40 gives id_pred=11, and id_branch with id_pc_imm=0x80 gives pc=0x80 and id_flush=1.
REQ-032 SHALL pass the mispredict case: ex_pred_taken=1, ex_taken=0, ex_pc=0x100 -> pc=0x104, id_flush=ex_flush=1, mispred_count+1.
REQ-033 SHALL pass the priority case: in the same cycle, ex_jalr with ex_rs1_imm=0x203 and id_jal with id_pc_imm=0x300 -> pc=0x202, ex_flush=1.
REQ-034 SHALL pass the stall case: stall=1 for 2 cycles during an EX branch -> pc, id_pred, BHT and counters unchanged; the update applies on the first stall=0 cycle only.
REQ-035 SHALL pass the wrap/saturation case: pc=0xFFFF_FFFC -> 0; with CNT_W=4, 20 branches -> br_count=4'hF.
